instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 16'd2: PC increment per fetched instruction (byte-addressed, 16-bit instructions).
REQ-003 Parameter HALT_OPCODE, default 4'hF: value of Instruction[15:12] that marks a HALT instruction.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 PC  output  16  fetch address driven to InstructionMemory; registered.
REQ-007 Instruction  input  16  InstructionMemory read data; combinational from PC, valid in the same cycle.
REQ-008 RedirectValid  input  1  branch/jump request from execute.
REQ-009 RedirectTarget  input  16  branch/jump target address.
REQ-010 IR  output  16  fetched instruction held for decode; registered.
REQ-011 IRPC  output  16  address the current IR was fetched from; registered.
REQ-012 IRValid  output  1  IR/IRPC hold an instruction not yet accepted.
REQ-013 IRReady  input  1  decode accepts IR this cycle when IRValid && IRReady.
REQ-014 Halted  output  1  high while the FSM is in HALTED.
REQ-015 InstrCount  output  16  number of instructions accepted by decode since reset.

Function
REQ-016 The FSM SHALL have exactly two states, RUN and HALTED; Halted is 1 iff the state is HALTED.
REQ-017 Accept SHALL be defined as IRValid && IRReady in a given cycle.
REQ-018 Load SHALL be defined as state==RUN && !RedirectValid && (!IRValid || IRReady).
REQ-019 On Load: IR<=Instruction, IRPC<=PC, IRValid<=1.
REQ-020 On Load with Instruction[15:12]!=HALT_OPCODE: PC<=PC+PC_STEP, modulo 2^16 (16'hFFFE+2 wraps to 16'h0000).
REQ-021 On Load with Instruction[15:12]==HALT_OPCODE: PC holds its value and the state becomes HALTED.
REQ-022 In RUN with no Load and no redirect (IRValid && !IRReady), PC, IR, IRPC and IRValid SHALL hold.
REQ-023 In HALTED with no redirect: no Load occurs, PC holds, and Accept clears IRValid to 0 next cycle.
REQ-024 RedirectValid=1 in any state: PC<=RedirectTarget with bit 0 forced to 0, IRValid<=0, state<=RUN, IR/IRPC hold, and no Load that cycle.
REQ-025 An Accept coinciding with RedirectValid SHALL still count as completed (InstrCount increments).
REQ-026 The first Load after a redirect SHALL occur in the cycle after the redirect (one bubble cycle).
REQ-027 InstrCount SHALL increment by 1 on each Accept and saturate at 16'hFFFF.
REQ-028 Fetch-to-IRValid latency SHALL be 1 cycle; with IRReady held at 1, one instruction is accepted per cycle.
REQ-029 RedirectValid SHALL take priority over Load and over the HALT transition; Reset SHALL take priority over everything.

Reset
REQ-030 With Reset=1 at a rising edge: PC<=RESET_PC, IR<=16'h0000, IRPC<=16'h0000, IRValid<=0, InstrCount<=0, state<=RUN (Halted=0), regardless of the other inputs.
REQ-031 Reset asserted mid-stall, while HALTED, or coincident with a redirect SHALL produce the REQ-030 state, discard any pending IR, and ignore the redirect.
REQ-032 The first Load SHALL occur in the first cycle with Reset=0, fetching from RESET_PC.

Verification
REQ-033 Reset, IRReady=1, memory returns 16'h1000+addr: IR sequence 16'h1000, 16'h1002, 16'h1004 with IRPC 0,2,4, IRValid=1 from the first post-reset cycle onward; InstrCount=3 after three Accepts.
REQ-034 IRReady=0 for 3 cycles with IRValid=1: PC, IR and IRPC stay constant and InstrCount is unchanged; on IRReady=1 the next instruction loads on the following edge.
REQ-035 RedirectValid=1 with RedirectTarget=16'h0041 while IRValid=1: next cycle PC=16'h0040, IRValid=0; the cycle after, IRPC=16'h0040 and IRValid=1.
REQ-036 The word at 16'h0006 is 16'hF000: after it loads, Halted=1, PC stays 16'h0006, and IRValid drops after its Accept; a redirect to 16'h0000 returns the state to RUN and fetch resumes.
REQ-037 RESET_PC=16'hFFFE, IRReady=1: IRPC 16'hFFFE, then 16'h0000 (wrap); Reset asserted while HALTED gives PC=16'hFFFE, IRValid=0, Halted=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives a fetch address to a combinational
// instruction memory and holds the fetched word in IR until decode takes it.
// A two-state FSM (RUN/HALTED) stops fetching after a HALT opcode, and a
// redirect from execute restarts it.
//
// Ports
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   PC                fetch address to instruction memory (registered)
//   Instruction       memory read data for PC, valid in the same cycle
//   RedirectValid     branch/jump request from execute
//   RedirectTarget    branch/jump target (bit 0 is ignored)
//   IR, IRPC          held instruction and its fetch address (registered)
//   IRValid           IR/IRPC hold an instruction decode has not taken
//   IRReady           decode takes IR when IRValid && IRReady
//   Halted            high while the FSM is in HALTED
//   InstrCount        saturating count of instructions taken by decode
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] PC_STEP     = 16'd2,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [15:0] PC,
   input  logic [15:0] Instruction,
   input  logic        RedirectValid,
   input  logic [15:0] RedirectTarget,
   output logic [15:0] IR,
   output logic [15:0] IRPC,
   output logic        IRValid,
   input  logic        IRReady,
   output logic        Halted,
   output logic [15:0] InstrCount
);

   localparam int unsigned W      = 16;
   localparam int unsigned OP_MSB = 15;
   localparam int unsigned OP_LSB = 12;

   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] HALTED = 1'b1;

   localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};

   logic [0:0]   state;
   logic [0:0]   state_nx;
   logic [W-1:0] pc_nx;
   logic [W-1:0] ir_nx;
   logic [W-1:0] irpc_nx;
   logic         irvalid_nx;
   logic [W-1:0] count_nx;

   logic         accept;
   logic         load;
   logic         is_halt;
   logic [W-1:0] redirect_pc;

   // Handshake and fetch qualifiers
   assign accept      = IRValid && IRReady;
   assign load        = (state == RUN) && !RedirectValid && (!IRValid || IRReady);
   assign is_halt     = (Instruction[OP_MSB:OP_LSB] == HALT_OPCODE);
   // Instructions are halfword aligned, so the target is forced even
   assign redirect_pc = {RedirectTarget[W-1:1], 1'b0};

   assign Halted = (state == HALTED);

   // State register and datapath registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= RUN;
         PC         <= RESET_PC;
         IR         <= '0;
         IRPC       <= '0;
         IRValid    <= 1'b0;
         InstrCount <= '0;
      end else begin
         state      <= state_nx;
         PC         <= pc_nx;
         IR         <= ir_nx;
         IRPC       <= irpc_nx;
         IRValid    <= irvalid_nx;
         InstrCount <= count_nx;
      end
   end

   // Next-state and next-datapath logic; redirect outranks load and halt
   always_comb begin
      state_nx   = state;
      pc_nx      = PC;
      ir_nx      = IR;
      irpc_nx    = IRPC;
      irvalid_nx = IRValid;
      count_nx   = InstrCount;

      // An accept still completes even when a redirect squashes fetch
      if (accept && (InstrCount != COUNT_MAX)) begin
         count_nx = InstrCount + W'(1);
      end

      if (RedirectValid) begin
         state_nx   = RUN;
         pc_nx      = redirect_pc;
         irvalid_nx = 1'b0;
      end else if (load) begin
         ir_nx      = Instruction;
         irpc_nx    = PC;
         irvalid_nx = 1'b1;
         if (is_halt) begin
            state_nx = HALTED;
         end else begin
            pc_nx = PC + PC_STEP;
         end
      end else if (accept) begin
         // Only reachable in HALTED: the last instruction drains out
         irvalid_nx = 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios against fixed
// expectations plus a randomized run against a behavioural model.
module tb_instruction_fetch_unit;

   logic        Clock;
   logic        Reset;
   logic [15:0] PC;
   logic [15:0] Instruction;
   logic        RedirectValid;
   logic [15:0] RedirectTarget;
   logic [15:0] IR;
   logic [15:0] IRPC;
   logic        IRValid;
   logic        IRReady;
   logic        Halted;
   logic [15:0] InstrCount;

   // Second instance with a reset PC at the top of the address space
   logic        Reset1;
   logic [15:0] PC1;
   logic [15:0] Instruction1;
   logic        RedirectValid1;
   logic [15:0] RedirectTarget1;
   logic [15:0] IR1;
   logic [15:0] IRPC1;
   logic        IRValid1;
   logic        IRReady1;
   logic        Halted1;
   logic [15:0] InstrCount1;

   logic [15:0] mem [0:65535];

   int checks;
   int errors;

   // Behavioural model of the architected state
   logic [15:0] m_pc;
   logic [15:0] m_ir;
   logic [15:0] m_irpc;
   bit          m_valid;
   bit          m_halt;
   logic [15:0] m_cnt;

   assign Instruction  = mem[PC];
   assign Instruction1 = mem[PC1];

   instruction_fetch_unit dut (
      .Clock(Clock), .Reset(Reset), .PC(PC), .Instruction(Instruction),
      .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
      .IR(IR), .IRPC(IRPC), .IRValid(IRValid), .IRReady(IRReady),
      .Halted(Halted), .InstrCount(InstrCount)
   );

   instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
      .Clock(Clock), .Reset(Reset1), .PC(PC1), .Instruction(Instruction1),
      .RedirectValid(RedirectValid1), .RedirectTarget(RedirectTarget1),
      .IR(IR1), .IRPC(IRPC1), .IRValid(IRValid1), .IRReady(IRReady1),
      .Halted(Halted1), .InstrCount(InstrCount1)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Apply one cycle of inputs to dut, advance the model, sample #1 after the edge
   task automatic tick(input bit rst, input bit rv, input logic [15:0] rt, input bit rdy);
      logic [15:0] word;
      bit          taken;
      bit          fetching;
      Reset          = rst;
      RedirectValid  = rv;
      RedirectTarget = rt;
      IRReady        = rdy;
      word     = mem[m_pc];
      taken    = m_valid && rdy;
      fetching = !m_halt && (!m_valid || rdy);
      if (rst) begin
         m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
         m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0000;
      end else begin
         if (taken && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (rv) begin
            m_pc = rt & 16'hFFFE;
            m_valid = 1'b0;
            m_halt = 1'b0;
         end else if (fetching) begin
            m_ir = word;
            m_irpc = m_pc;
            m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
         end else if (taken) begin
            m_valid = 1'b0;
         end
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b1, 16'h1234, 1'b1);
      tick(1'b1, 1'b1, 16'h5678, 1'b0);
      checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", PC); end
      checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", IR); end
      checks++; if (IRPC !== 16'h0000) begin errors++; $display("FAIL reset_irpc got %h exp 0000", IRPC); end
      checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL reset_irvalid got %b exp 0", IRValid); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", Halted); end
      checks++; if (InstrCount !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", InstrCount); end
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 16'h0000, 1'b1);
         checks++; if (IR !== 16'h1000 + 16'(2*k)) begin errors++; $display("FAIL seq_ir k=%0d got %h exp %h", k, IR, 16'h1000 + 16'(2*k)); end
         checks++; if (IRPC !== 16'(2*k)) begin errors++; $display("FAIL seq_irpc k=%0d got %h exp %h", k, IRPC, 16'(2*k)); end
         checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL seq_irvalid k=%0d got %b exp 1", k, IRValid); end
         checks++; if (InstrCount !== 16'(k)) begin errors++; $display("FAIL seq_count k=%0d got %0d exp %0d", k, InstrCount, k); end
      end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0, 16'h0000, 1'b0);
         checks++; if (PC !== 16'h0008) begin errors++; $display("FAIL stall_pc k=%0d got %h exp 0008", k, PC); end
         checks++; if (IR !== 16'h1006) begin errors++; $display("FAIL stall_ir k=%0d got %h exp 1006", k, IR); end
         checks++; if (IRPC !== 16'h0006) begin errors++; $display("FAIL stall_irpc k=%0d got %h exp 0006", k, IRPC); end
         checks++; if (InstrCount !== 16'd3) begin errors++; $display("FAIL stall_count k=%0d got %0d exp 3", k, InstrCount); end
      end
      tick(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (IR !== 16'h1008) begin errors++; $display("FAIL unstall_ir got %h exp 1008", IR); end
      checks++; if (IRPC !== 16'h0008) begin errors++; $display("FAIL unstall_irpc got %h exp 0008", IRPC); end
      checks++; if (InstrCount !== 16'd4) begin errors++; $display("FAIL unstall_count got %0d exp 4", InstrCount); end
   endtask

   task automatic test_redirect();
      tick(1'b0, 1'b1, 16'h0041, 1'b1);
      checks++; if (PC !== 16'h0040) begin errors++; $display("FAIL redir_pc got %h exp 0040", PC); end
      checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL redir_irvalid got %b exp 0", IRValid); end
      checks++; if (IR !== 16'h1008) begin errors++; $display("FAIL redir_ir_hold got %h exp 1008", IR); end
      checks++; if (InstrCount !== 16'd5) begin errors++; $display("FAIL redir_count got %0d exp 5", InstrCount); end
      tick(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (IRPC !== 16'h0040) begin errors++; $display("FAIL redir_irpc got %h exp 0040", IRPC); end
      checks++; if (IR !== 16'h1040) begin errors++; $display("FAIL redir_ir got %h exp 1040", IR); end
      checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL redir_resume got %b exp 1", IRValid); end
      checks++; if (PC !== 16'h0042) begin errors++; $display("FAIL redir_nextpc got %h exp 0042", PC); end
   endtask

   task automatic test_halt();
      mem[16'h0006] = 16'hF000;
      tick(1'b1, 1'b0, 16'h0000, 1'b1);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (IR !== 16'hF000) begin errors++; $display("FAIL halt_ir got %h exp f000", IR); end
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_state got %b exp 1", Halted); end
      checks++; if (PC !== 16'h0006) begin errors++; $display("FAIL halt_pc got %h exp 0006", PC); end
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL halt_hold_valid got %b exp 1", IRValid); end
      checks++; if (InstrCount !== 16'd3) begin errors++; $display("FAIL halt_hold_count got %0d exp 3", InstrCount); end
      tick(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL halt_drain got %b exp 0", IRValid); end
      checks++; if (InstrCount !== 16'd4) begin errors++; $display("FAIL halt_drain_count got %0d exp 4", InstrCount); end
      tick(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (PC !== 16'h0006 || IRValid !== 1'b0 || Halted !== 1'b1) begin errors++; $display("FAIL halt_idle got pc=%h v=%b h=%b exp pc=0006 v=0 h=1", PC, IRValid, Halted); end
      tick(1'b0, 1'b1, 16'h0000, 1'b1);
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_exit got %b exp 0", Halted); end
      checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL halt_exit_pc got %h exp 0000", PC); end
      tick(1'b0, 1'b0, 16'h0000, 1'b1);
      checks++; if (IRValid !== 1'b1 || IRPC !== 16'h0000 || IR !== 16'h1000) begin errors++; $display("FAIL halt_resume got v=%b irpc=%h ir=%h exp v=1 irpc=0000 ir=1000", IRValid, IRPC, IR); end
      mem[16'h0006] = 16'h1006;
   endtask

   task automatic test_wrap();
      Reset1 = 1'b1; IRReady1 = 1'b1; RedirectValid1 = 1'b0; RedirectTarget1 = 16'h0000;
      @(posedge Clock); #1;
      checks++; if (PC1 !== 16'hFFFE) begin errors++; $display("FAIL wrap_reset_pc got %h exp fffe", PC1); end
      Reset1 = 1'b0;
      @(posedge Clock); #1;
      checks++; if (IRPC1 !== 16'hFFFE || IRValid1 !== 1'b1) begin errors++; $display("FAIL wrap_first got irpc=%h v=%b exp irpc=fffe v=1", IRPC1, IRValid1); end
      checks++; if (PC1 !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", PC1); end
      @(posedge Clock); #1;
      checks++; if (IRPC1 !== 16'h0000) begin errors++; $display("FAIL wrap_irpc got %h exp 0000", IRPC1); end
      mem[16'h0002] = 16'hF000;
      @(posedge Clock); #1;
      checks++; if (Halted1 !== 1'b1 || PC1 !== 16'h0002) begin errors++; $display("FAIL wrap_halt got h=%b pc=%h exp h=1 pc=0002", Halted1, PC1); end
      Reset1 = 1'b1;
      @(posedge Clock); #1;
      checks++; if (PC1 !== 16'hFFFE || IRValid1 !== 1'b0 || Halted1 !== 1'b0 || InstrCount1 !== 16'h0000) begin errors++; $display("FAIL wrap_halt_reset got pc=%h v=%b h=%b n=%h exp pc=fffe v=0 h=0 n=0000", PC1, IRValid1, Halted1, InstrCount1); end
      mem[16'h0002] = 16'h1002;
   endtask

   task automatic test_random();
      bit          rst;
      bit          rv;
      bit          rdy;
      logic [15:0] rt;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      tick(1'b1, 1'b0, 16'h0000, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         rv  = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rt  = 16'($urandom);
         tick(rst, rv, rt, rdy);
         checks++; if (PC !== m_pc) begin errors++; $display("FAIL rand_pc c=%0d got %h exp %h", c, PC, m_pc); end
         checks++; if (IR !== m_ir) begin errors++; $display("FAIL rand_ir c=%0d got %h exp %h", c, IR, m_ir); end
         checks++; if (IRPC !== m_irpc) begin errors++; $display("FAIL rand_irpc c=%0d got %h exp %h", c, IRPC, m_irpc); end
         checks++; if (IRValid !== m_valid) begin errors++; $display("FAIL rand_irvalid c=%0d got %b exp %b", c, IRValid, m_valid); end
         checks++; if (Halted !== m_halt) begin errors++; $display("FAIL rand_halted c=%0d got %b exp %b", c, Halted, m_halt); end
         checks++; if (InstrCount !== m_cnt) begin errors++; $display("FAIL rand_count c=%0d got %h exp %h", c, InstrCount, m_cnt); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
      m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0000;
      Reset = 1'b1; RedirectValid = 1'b0; RedirectTarget = 16'h0000; IRReady = 1'b0;
      Reset1 = 1'b1; RedirectValid1 = 1'b0; RedirectTarget1 = 16'h0000; IRReady1 = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
